// File: rtl/usb_packet_scheduler.sv
// Byte sequencer between the FT232H USB interface and a synchronous sample memory.
// One received command byte yields an echo of that byte followed by NR_WORDS memory bytes.
module usb_packet_scheduler #(
  parameter int unsigned NR_WORDS = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned TO_W     = 20
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              byte_received_i,
  input  logic [7:0]        read_data_i,
  input  logic              usb_write_done_i,
  output logic              write_request_o,
  output logic [7:0]        write_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_data_i,
  output logic              busy_o,
  output logic              packet_done_o,
  output logic              cmd_dropped_o,
  output logic              timeout_err_o
);

  typedef enum logic [2:0] {
    StIdle, StEcho, StFetch, StLoad, StReq, StWaitDone, StNext
  } state_e;

  localparam logic [8:0]      NrWordsC = 9'(NR_WORDS);
  localparam logic [TO_W-1:0] ToLast   = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [8:0]        word_cnt_q, word_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              echo_q, echo_d;
  logic              wr_req_q, wr_req_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              to_err_q, to_err_d;
  logic [8:0]        cnt_after;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    word_cnt_d = word_cnt_q;
    to_cnt_d   = to_cnt_q;
    echo_d     = echo_q;
    wr_req_d   = wr_req_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    to_err_d   = 1'b0;
    drop_d     = byte_received_i && (state_q != StIdle);
    // Data bytes advance the count; the echo byte does not.
    cnt_after  = word_cnt_q + {8'd0, ~echo_q};

    case (state_q)
      StIdle: begin
        if (byte_received_i) begin
          addr_d     = ADDR_W'(read_data_i);
          cmd_d      = read_data_i;
          busy_d     = 1'b1;
          word_cnt_d = '0;
          state_d    = StEcho;
        end
      end
      StEcho: begin
        wr_data_d = cmd_q;
        echo_d    = 1'b1;
        state_d   = StReq;
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        wr_data_d = mem_data_i;
        echo_d    = 1'b0;
        state_d   = StReq;
      end
      StReq: begin
        wr_req_d = 1'b1;
        to_cnt_d = '0;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        // Dropping the request on the done edge keeps the interface from re-sending the byte.
        if (usb_write_done_i) begin
          wr_req_d = 1'b0;
          state_d  = StNext;
        end else if (to_cnt_q == ToLast) begin
          wr_req_d = 1'b0;
          to_err_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StNext: begin
        if (cnt_after == NrWordsC) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          word_cnt_d = cnt_after;
          if (!echo_q) addr_d = addr_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cmd_q      <= '0;
      word_cnt_q <= '0;
      to_cnt_q   <= '0;
      echo_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      word_cnt_q <= word_cnt_d;
      to_cnt_q   <= to_cnt_d;
      echo_q     <= echo_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      to_err_q   <= to_err_d;
    end
  end

  assign write_request_o = wr_req_q;
  assign write_data_o    = wr_data_q;
  assign mem_addr_o      = addr_q;
  assign mem_rd_o        = (state_q == StFetch);
  assign busy_o          = busy_q;
  assign packet_done_o   = done_q;
  assign cmd_dropped_o   = drop_q;
  assign timeout_err_o   = to_err_q;

endmodule

// File: tb/tb_usb_packet_scheduler.sv
// Bench for usb_packet_scheduler: USB-interface and memory models, a packet-level reference
// model feeding scoreboard queues, and negedge monitors that pop and compare.
module tb_usb_packet_scheduler;

  localparam int unsigned NrWords = 4;
  localparam int unsigned Timeout = 100;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       byte_received = 1'b0;
  logic [7:0] read_data = 8'h00;
  logic       usb_write_done = 1'b0;
  logic       write_request;
  logic [7:0] write_data;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data = 8'h00;
  logic       busy, packet_done, cmd_dropped, timeout_err;

  usb_packet_scheduler #(
    .NR_WORDS(NrWords),
    .ADDR_W  (8),
    .TIMEOUT (Timeout),
    .TO_W    (8)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .byte_received_i (byte_received),
    .read_data_i     (read_data),
    .usb_write_done_i(usb_write_done),
    .write_request_o (write_request),
    .write_data_o    (write_data),
    .mem_addr_o      (mem_addr),
    .mem_rd_o        (mem_rd),
    .mem_data_i      (mem_data),
    .busy_o          (busy),
    .packet_done_o   (packet_done),
    .cmd_dropped_o   (cmd_dropped),
    .timeout_err_o   (timeout_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  logic [7:0] exp_byte_q[$];
  logic [7:0] exp_addr_q[$];
  int n_done = 0, n_drop = 0, n_to = 0, writes = 0;
  int u_state = 0, u_cnt = 0, u_delay = 3;
  bit u_no_done = 1'b0;
  logic [7:0] u_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
  endtask

  // Reference model: echo, then NR_WORDS bytes from consecutive addresses modulo 256.
  task automatic push_packet(input logic [7:0] cmd);
    exp_byte_q.push_back(cmd);
    for (int i = 0; i < int'(NrWords); i++) begin
      logic [7:0] a;
      a = 8'((int'(cmd) + i) % 256);
      exp_addr_q.push_back(a);
      exp_byte_q.push_back(mem[a]);
    end
  endtask

  always @(posedge CLOCK_50) if (mem_rd) mem_data <= mem[mem_addr];

  // USB interface model: accepts a byte when idle and request is high, holds done for one cycle,
  // then returns to idle and samples the request again (a late drop shows up as a duplicate).
  always @(negedge CLOCK_50) begin
    if (reset) begin
      u_state = 0;
      usb_write_done = 1'b0;
    end else begin
      if (u_state == 2) begin
        usb_write_done = 1'b0;
        u_state = 0;
      end else if (u_state == 1) begin
        if (!write_request) u_state = 0;
        else begin
          check("wdata_stable", write_data, u_byte);
          if (!u_no_done) begin
            if (u_cnt <= 0) begin
              usb_write_done = 1'b1;
              u_state = 2;
            end else u_cnt--;
          end
        end
      end
      if (u_state == 0 && write_request) begin
        writes++;
        u_byte = write_data;
        u_state = 1;
        u_cnt = ((u_delay != 0) ? u_delay : int'($urandom_range(2, 8))) - 2;
        if (exp_byte_q.size() == 0) unexpected("write_byte", write_data);
        else check("write_byte", write_data, exp_byte_q.pop_front());
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) unexpected("mem_addr", mem_addr);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (packet_done) n_done++;
      if (cmd_dropped) n_drop++;
      if (timeout_err) n_to++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    read_data = b;
    byte_received = 1'b1;
    @(negedge CLOCK_50);
    byte_received = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("idle_in_budget", busy, 1'b0);
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic run_packet(input logic [7:0] cmd, input int delay, input int drop_after,
                            input logic [7:0] drop_byte);
    int d0, w0, r0, exp_drops;
    u_delay = delay;
    d0 = n_done;
    w0 = writes;
    r0 = n_drop;
    exp_drops = 0;
    push_packet(cmd);
    send_byte(cmd);
    check("busy_set", busy, 1'b1);
    if (drop_after > 0) begin
      repeat (drop_after) @(negedge CLOCK_50);
      if (busy === 1'b1) begin
        read_data = drop_byte;
        byte_received = 1'b1;
        @(negedge CLOCK_50);
        byte_received = 1'b0;
        exp_drops = 1;
      end
    end
    wait_idle(2000);
    check("packet_done_cnt", n_done - d0, 1);
    check("write_cnt", writes - w0, NrWords + 1);
    check("drop_cnt", n_drop - r0, exp_drops);
    check("bytes_left", exp_byte_q.size(), 0);
    check("addrs_left", exp_addr_q.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, hi, d0, t0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", {write_request, write_data, mem_addr, mem_rd, busy, packet_done,
                            cmd_dropped, timeout_err}, '0);
    reset = 1'b0;

    // Reset asserted mid-cycle while a request is outstanding.
    u_delay = 6;
    d0 = n_done;
    push_packet(8'h55);
    send_byte(8'h55);
    n = 0;
    while (!write_request && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("req_before_reset", write_request, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", {write_request, write_data, mem_addr, mem_rd, busy,
                                     packet_done, cmd_dropped, timeout_err}, '0);
    exp_byte_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("idle_after_reset", {busy, write_request, mem_rd}, '0);
    check("no_done_after_reset", n_done - d0, 0);

    run_packet(8'h10, 3, 0, 8'h00);
    run_packet(8'hFE, 3, 0, 8'h00);
    run_packet(8'h10, 3, 5, 8'h33);

    // Timeout: the interface never signals done for the echo byte.
    u_no_done = 1'b1;
    t0 = n_to;
    exp_byte_q.push_back(8'h40);
    send_byte(8'h40);
    n = 0;
    while (!write_request && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    hi = 0;
    while (write_request && hi < 300) begin
      @(negedge CLOCK_50);
      hi++;
    end
    check("timeout_len", hi, Timeout);
    check("timeout_err_level", timeout_err, 1'b1);
    check("busy_after_timeout", busy, 1'b0);
    u_no_done = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("timeout_pulses", n_to - t0, 1);
    check("timeout_bytes_left", exp_byte_q.size(), 0);
    run_packet(8'h20, 3, 0, 8'h00);

    for (int k = 0; k < 24; k++) begin
      run_packet(8'($urandom), 0, int'($urandom_range(0, 30)), 8'($urandom));
    end
    check("no_spurious_timeout", n_to - t0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
